// File: rtl/ap_pkg.sv
// Shared command codes and widths for the pointer-select unit.
package ap_pkg;
  localparam int SEL_W = 3;

  localparam logic [3:0] CMD_HOLD     = 4'd0;
  localparam logic [3:0] CMD_SEL_BASE = 4'd1;
  localparam logic [3:0] CMD_INC      = 4'd9;
  localparam logic [3:0] CMD_DEC      = 4'd10;
  localparam logic [3:0] CMD_SWAP     = 4'd11;
  localparam logic [3:0] CMD_SAVE     = 4'd12;
  localparam logic [3:0] CMD_RESTORE  = 4'd13;
  localparam logic [3:0] CMD_CLR      = 4'd14;
  localparam logic [3:0] CMD_RSVD     = 4'd15;
endpackage

// File: rtl/ap_selector.sv
// Registered 3-bit pointer select driven by 4-bit decoder commands,
// with a one-deep "previous" history for swap and an explicit save slot.
module ap_selector
  import ap_pkg::*;
#(
  parameter logic [SEL_W-1:0] RESET_SEL = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       APSet,
  output logic [SEL_W-1:0] APSel
);

  logic [SEL_W-1:0] prev;
  logic [SEL_W-1:0] shadow;
  logic [SEL_W-1:0] sel_n;
  logic [SEL_W-1:0] prev_n;
  logic [SEL_W-1:0] shadow_n;
  logic [3:0]       direct;
  logic             tracks_prev;

  assign direct = APSet - CMD_SEL_BASE;

  always_comb begin
    sel_n       = APSel;
    prev_n      = prev;
    shadow_n    = shadow;
    tracks_prev = 1'b0;
    case (APSet)
      CMD_HOLD, CMD_RSVD: ;
      CMD_INC: begin
        sel_n       = APSel + 3'd1;
        tracks_prev = 1'b1;
      end
      CMD_DEC: begin
        sel_n       = APSel - 3'd1;
        tracks_prev = 1'b1;
      end
      CMD_SWAP: begin
        sel_n  = prev;
        prev_n = APSel;
      end
      CMD_SAVE: shadow_n = APSel;
      CMD_RESTORE: begin
        sel_n       = shadow;
        tracks_prev = 1'b1;
      end
      CMD_CLR: begin
        sel_n       = RESET_SEL;
        tracks_prev = 1'b1;
      end
      default: begin
        sel_n       = direct[SEL_W-1:0];
        tracks_prev = 1'b1;
      end
    endcase
    // prev only remembers real changes, so re-loading the same slot keeps history
    if (tracks_prev && (sel_n != APSel)) prev_n = APSel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      APSel  <= RESET_SEL;
      prev   <= RESET_SEL;
      shadow <= RESET_SEL;
    end else begin
      APSel  <= sel_n;
      prev   <= prev_n;
      shadow <= shadow_n;
    end
  end

endmodule

// File: tb/tb_ap_selector.sv
// Scoreboard bench for ap_selector: directed plan followed by random commands
// with occasional asynchronous resets, checked against a behavioural model.
module tb_ap_selector;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] APSet = 4'd0;
  logic [2:0] APSel;

  logic [2:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // behavioural model state
  int m_sel = 0;
  int m_prev = 0;
  int m_shadow = 0;

  ap_selector #(.RESET_SEL(3'd0)) dut (
    .clk(clk),
    .rst(rst),
    .APSet(APSet),
    .APSel(APSel)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_sel = 0;
    m_prev = 0;
    m_shadow = 0;
  endtask

  task automatic model_apply(input int cmd);
    int nxt;
    nxt = m_sel;
    if (cmd == 11) begin
      nxt = m_prev;
      m_prev = m_sel;
      m_sel = nxt;
    end else if (cmd == 12) begin
      m_shadow = m_sel;
    end else if (cmd != 0 && cmd != 15) begin
      if (cmd >= 1 && cmd <= 8) nxt = cmd - 1;
      else if (cmd == 9)        nxt = (m_sel + 1) % 8;
      else if (cmd == 10)       nxt = (m_sel + 7) % 8;
      else if (cmd == 13)       nxt = m_shadow;
      else                      nxt = 0;
      if (nxt != m_sel) m_prev = m_sel;
      m_sel = nxt;
    end
  endtask

  // driver: one command per cycle, expected value queued for the next edge
  task automatic drive(input int cmd);
    @(negedge clk);
    APSet = cmd[3:0];
    model_apply(cmd);
    exp_q.push_back(m_sel[2:0]);
  endtask

  // asynchronous reset placed between edges, checked before any edge follows
  task automatic async_reset();
    @(posedge clk);
    #3;
    APSet = 4'd0;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset", APSel, 3'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: compare after each rising edge whenever a result is pending
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("apsel", APSel, exp_q.pop_front());
    end
  end

  initial begin
    // reset with no clock edges yet
    #1;
    rst = 1'b1;
    #1;
    check("reset_immediate", APSel, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", APSel, 3'd0);
    rst = 1'b0;
    model_reset();
    drive(0); drive(0);

    // direct select sweep then hold
    for (int c = 1; c <= 8; c++) drive(c);
    drive(0);

    // wrap tests
    drive(8); drive(9);
    drive(1); drive(10);

    // swap and prev
    drive(3); drive(6); drive(11);
    drive(11);
    drive(6); drive(11);

    // save / restore / clear / reserved
    drive(5); drive(12); drive(2); drive(13);
    drive(14); drive(15);

    // async reset mid-operation, shadow must be lost
    drive(12);
    drive(7);
    async_reset();
    drive(13);
    drive(0);

    // randomized commands with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) async_reset();
      else drive($urandom_range(0, 15));
    end
    drive(0);

    // drain with a bounded wait
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d results pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
